// File: rtl/data_memory_responder.sv
// Data memory serving the core's load/store port: combinational reads,
// byte-enabled synchronous writes, post-reset clearing and sticky error capture.
module data_memory_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        mem_busy,
    output logic        mis_err,
    output logic [31:0] err_addr
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              ready;
    logic              is_b, is_h, is_w;
    logic              aligned, rd_ok, wr_ok;
    logic              illegal, do_wr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_word, shifted;
    logic              unused_addr_bits;

    assign idx   = MEM_addr[ADDR_W+1:2];
    assign off   = MEM_addr[1:0];
    assign ready = (state_q == READY);
    assign unused_addr_bits = ^MEM_addr[31:ADDR_W+2];

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        is_w = 1'b0;
        unique case (MEM_type)
            3'b000, 3'b100: is_b = 1'b1;
            3'b001, 3'b101: is_h = 1'b1;
            3'b010:         is_w = 1'b1;
            default:        ;
        endcase
    end

    assign aligned = is_b | (is_h & ~off[0]) | (is_w & (off == 2'b00));
    assign rd_ok   = aligned;
    assign wr_ok   = aligned & ~MEM_type[2];
    assign illegal = ready & ((MEM_rd_en & ~rd_ok) | (MEM_wr_en & ~wr_ok));
    assign do_wr   = ready & MEM_wr_en & ~illegal;

    always_comb begin
        be    = 4'b0000;
        wdata = MEM_WR_out;
        if (is_b) begin
            be    = 4'b0001 << off;
            wdata = {4{MEM_WR_out[7:0]}};
        end else if (is_h) begin
            be    = 4'b0011 << off;
            wdata = {2{MEM_WR_out[15:0]}};
        end else if (is_w) begin
            be    = 4'b1111;
        end
    end

    // State register and clear counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_cnt == ADDR_W'(DEPTH - 1))
            state_d = READY;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (state_q == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (do_wr) begin
                for (int i = 0; i < 4; i++)
                    if (be[i])
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Only the first erroring address since reset is kept
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mis_err  <= 1'b0;
            err_addr <= '0;
        end else if (illegal) begin
            mis_err <= 1'b1;
            if (!mis_err)
                err_addr <= MEM_addr;
        end
    end

    assign rd_word = mem[idx];
    assign shifted = rd_word >> {off, 3'b000};

    always_comb begin
        mem_busy = (state_q == CLEAR);
        MEM_data = '0;
        if (ready && MEM_rd_en && !illegal) begin
            unique case (MEM_type)
                3'b000:  MEM_data = {{24{shifted[7]}}, shifted[7:0]};
                3'b100:  MEM_data = {24'b0, shifted[7:0]};
                3'b001:  MEM_data = {{16{shifted[15]}}, shifted[15:0]};
                3'b101:  MEM_data = {16'b0, shifted[15:0]};
                3'b010:  MEM_data = rd_word;
                default: MEM_data = '0;
            endcase
        end
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Data-memory responder that serves the CPU core's stage-3 load/store port.
- It receives MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en and MEM_wr_en, and returns MEM_data in the same cycle: combinational read, synchronous sized writes.
- Includes a post-reset clearing sequencer that zeroes the whole array, and sticky misalignment error capture.
- Sits between the CPU top level and the testbench/SoC boundary.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two).
- ADDR_W, 8, log2(DEPTH); word index = MEM_addr[ADDR_W+1:2].

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- MEM_addr  input  32  byte address of access.
- MEM_WR_out  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
- MEM_type  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal.
- MEM_rd_en  input  1  load request this cycle.
- MEM_wr_en  input  1  store request this cycle.
- MEM_data  output  32  load result, right-justified, sign- or zero-extended per MEM_type.
- mem_busy  output  1  high while the clearing sequencer runs.
- mis_err  output  1  sticky misaligned/illegal-access flag.
- err_addr  output  32  MEM_addr of the first erroring access since reset.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset effects: on a cycle with Reset=1 at the CLK edge:
  - FSM goes to CLEAR and clr_cnt=0.
  - mis_err=0 and err_addr=0.
  - mem_busy reads 1 from the next cycle.
- FSM states: CLEAR and READY.
  - CLEAR: each cycle writes 0 to word[clr_cnt] and increments clr_cnt. When clr_cnt==DEPTH-1 has been written, go to READY. CLEAR therefore lasts exactly DEPTH cycles after Reset deasserts.
  - READY: normal service; stays in READY until Reset.
- Reset mid-CLEAR: clr_cnt returns to 0 and clearing restarts; no partial-completion exit.
- mem_busy = (state==CLEAR).
- While busy:
  - MEM_data=0.
  - Stores are dropped.
  - mis_err is not updated.
  - CPU requests are not stalled.
- Lane and alignment rules: byte offset is off=MEM_addr[1:0].
  - Byte access: any off is legal.
  - Half access: off must be 0 or 2.
  - Word access: off must be 0.
- Address aliasing: address bits above ADDR_W+1 are ignored; the address wraps modulo DEPTH*4.
- Loads (READY, MEM_rd_en=1, legal):
  - Read is combinational from word[idx]; zero added cycles.
  - B: {24{b[7]}, b}. BU: {24'b0, b}, where b = byte lane off.
  - H: sign-extend the halfword at lane off. HU: zero-extend it.
  - W: the full word.
  - MEM_data=0 whenever MEM_rd_en=0.
- Stores (READY, MEM_wr_en=1, legal): on the CLK edge, write the byte-enabled lanes only. Other lanes are unchanged.
  - SB: lane off gets MEM_WR_out[7:0].
  - SH: lanes off and off+1 get MEM_WR_out[15:0].
  - SW: all four lanes.
  - MEM_type 100/101 on a store is illegal.
- Illegal accesses (misaligned, or reserved MEM_type, with rd_en or wr_en high while READY):
  - No write occurs; MEM_data=0.
  - mis_err is set on the edge and stays set until Reset.
  - err_addr is captured only if mis_err was 0, so it holds the first error.
- Simultaneous MEM_rd_en and MEM_wr_en: the write is performed. MEM_data in that cycle shows the pre-write contents (read-before-write). The next cycle sees the new data.
- Back-to-back: store at cycle N followed by load at N+1 to the same address returns the stored value. No forwarding is needed beyond this.
- Reset values: mem_busy=1 (CLEAR), mis_err=0, err_addr=0, MEM_data=0.

Test Plan:
1. Reset high 1 cycle, then low → mem_busy=1 for exactly 256 cycles, then 0. A LW at 0x40 after that returns 0x00000000.
2. SW 0x8000_00FF to 0x10, then LB at 0x10 → 0xFFFF_FFFF. LBU at 0x13 → 0x0000_0080. LH at 0x12 → 0xFFFF_8000. LHU at 0x10 → 0x0000_00FF.
3. SB 0xAB to 0x21 over a word preloaded with 0x11223344 → LW at 0x20 returns 0x1122AB44. Then SH 0xBEEF to 0x22 → LW returns 0xBEEFAB44.
4. LW at 0x06, then SH at 0x33 → no write; mis_err=1 and err_addr=0x00000006 (the second error does not overwrite); MEM_data=0 on both.
5. Store 0x5 to 0x400 (DEPTH=256) → LW at 0x000 returns 0x5 (alias). In the same cycle, rd_en and wr_en both high to the same word: old value is shown, new value appears next cycle.
6. Reset asserted at clear cycle 100 → mem_busy stays high a further 256 cycles after deassert. A store during busy is dropped (a later LW returns 0).
